// File: rtl/peg_pkg.sv
// Shared types and board-geometry helpers for the peg-solitaire engine.
package peg_pkg;

    // Width of coordinates stored in the undo history; covers boards up to 255 cells wide.
    localparam int unsigned COORD_W = 8;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SCAN = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        dir_e               dir;
    } stack_entry_t;

    // True when (x,y) lies on the cross: inside the square and outside the four dead corners.
    function automatic logic cell_exists(input int x, input int y, input int width, input int arm);
        int   c;
        logic in_range;
        logic corner;
        c        = (width - arm) / 2;
        in_range = (x >= 0) && (y >= 0) && (x < width) && (y < width);
        corner   = ((x < c) || (x >= width - c)) && ((y < c) || (y >= width - c));
        return in_range && !corner;
    endfunction

    function automatic int dir_dx(input dir_e d);
        case (d)
            LEFT:    return -1;
            RIGHT:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int dir_dy(input dir_e d);
        case (d)
            UP:      return -1;
            DOWN:    return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/peg_undo_stack.sv
// Circular LIFO of applied moves; a push when full overwrites the oldest entry.
//  clk, rst   : clock, synchronous active-high reset (empties the stack)
//  push_i     : store data_i as the newest entry
//  pop_i      : discard the newest entry (ignored when empty)
//  data_i     : entry to push
//  top_c      : newest entry (combinational, meaningful when level_o > 0)
//  level_o    : number of entries currently held
module peg_undo_stack
    import peg_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  stack_entry_t  data_i,
    output stack_entry_t  top_c,
    output logic [LW-1:0] level_o
);

    stack_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   ptr_q;
    logic [LW-1:0]   level_q;

    // Write pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            level_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_q + AW'(1);
            if (level_q != LW'(DEPTH)) begin
                level_q <= level_q + LW'(1);
            end
        end else if (pop_i && (level_q != '0)) begin
            ptr_q   <= ptr_q - AW'(1);
            level_q <= level_q - LW'(1);
        end
    end

    // Storage needs no reset: entries are only read below the level count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

    assign top_c   = mem_q[ptr_q - AW'(1)];
    assign level_o = level_q;

endmodule

// File: rtl/peg_solitaire_engine.sv
// Peg-solitaire engine: cross board, handshaked move/undo commands, bounded undo,
// and a one-cell-per-cycle scan that decides game-over / win after each command.
//  clk, rst              : clock, synchronous active-high reset
//  cmd_valid / cmd_ready : command handshake (ready only in IDLE)
//  cmd_undo              : 1 = undo last move, 0 = move (cmd_x, cmd_y, cmd_dir)
//  rsp_valid / rsp_ok    : one-cycle completion pulse and applied/rejected flag
//  piece_count           : pegs on the board
//  undo_level            : moves currently undoable
//  game_over, won        : end-of-game status, refreshed with each response
module peg_solitaire_engine
    import peg_pkg::*;
#(
    parameter  int unsigned BOARD_WIDTH = 7,
    parameter  int unsigned ARM_WIDTH   = 3,
    parameter  int unsigned UNDO_DEPTH  = 8,
    localparam int unsigned C           = (BOARD_WIDTH - ARM_WIDTH) / 2,
    localparam int unsigned CW          = $clog2(BOARD_WIDTH),
    localparam int unsigned NCELLS      = BOARD_WIDTH * BOARD_WIDTH - 4 * C * C,
    localparam int unsigned PW          = $clog2(NCELLS + 1),
    localparam int unsigned UW          = $clog2(UNDO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_undo,
    input  logic [CW-1:0] cmd_x,
    input  logic [CW-1:0] cmd_y,
    input  logic [1:0]    cmd_dir,
    output logic          rsp_valid,
    output logic          rsp_ok,
    output logic [PW-1:0] piece_count,
    output logic [UW-1:0] undo_level,
    output logic          game_over,
    output logic          won
);

    localparam int unsigned NB     = BOARD_WIDTH * BOARD_WIDTH;
    localparam int unsigned IW     = $clog2(NB);
    localparam int unsigned MID    = BOARD_WIDTH / 2;
    localparam int unsigned CENTRE = MID * BOARD_WIDTH + MID;

    function automatic logic [IW-1:0] cell_idx(input int x, input int y);
        return IW'(y * int'(BOARD_WIDTH) + x);
    endfunction

    function automatic logic [NB-1:0] init_board();
        logic [NB-1:0] b;
        b = '0;
        for (int y = 0; y < int'(BOARD_WIDTH); y++) begin
            for (int x = 0; x < int'(BOARD_WIDTH); x++) begin
                b[cell_idx(x, y)] = cell_exists(x, y, int'(BOARD_WIDTH), int'(ARM_WIDTH)) &&
                                    !((x == int'(MID)) && (y == int'(MID)));
            end
        end
        return b;
    endfunction

    localparam logic [NB-1:0] INIT_BOARD = init_board();

    // Shared by command execution and the game-over scan.
    function automatic logic move_legal(input logic [NB-1:0] b, input int x, input int y, input dir_e d);
        int   dx;
        int   dy;
        logic ok;
        dx = dir_dx(d);
        dy = dir_dy(d);
        ok = cell_exists(x, y, int'(BOARD_WIDTH), int'(ARM_WIDTH)) &&
             cell_exists(x + dx, y + dy, int'(BOARD_WIDTH), int'(ARM_WIDTH)) &&
             cell_exists(x + 2 * dx, y + 2 * dy, int'(BOARD_WIDTH), int'(ARM_WIDTH));
        if (ok) begin
            ok = b[cell_idx(x, y)] && b[cell_idx(x + dx, y + dy)] &&
                 !b[cell_idx(x + 2 * dx, y + 2 * dy)];
        end
        return ok;
    endfunction

    state_e        state_q, state_d;
    logic [NB-1:0] board_q, board_d;
    logic [PW-1:0] count_q, count_d;
    logic          cmd_undo_q, cmd_undo_d;
    logic [CW-1:0] cmd_x_q, cmd_x_d;
    logic [CW-1:0] cmd_y_q, cmd_y_d;
    dir_e          cmd_dir_q, cmd_dir_d;
    logic [CW-1:0] scan_x_q, scan_x_d;
    logic [CW-1:0] scan_y_q, scan_y_d;
    logic          any_q, any_d;
    logic          ok_q, ok_d;
    logic          from_cmd_q, from_cmd_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_ok_q, rsp_ok_d;
    logic          game_over_q, game_over_d;
    logic          won_q, won_d;
    logic          ready_q, ready_d;

    logic          push_c;
    logic          pop_c;
    logic          scan_hit_c;
    stack_entry_t  push_entry_c;
    stack_entry_t  top_entry_c;
    logic [UW-1:0] level;

    peg_undo_stack #(.DEPTH(UNDO_DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (push_entry_c),
        .top_c   (top_entry_c),
        .level_o (level)
    );

    // Any legal direction from the cell currently under the scan.
    assign scan_hit_c = move_legal(board_q, int'(scan_x_q), int'(scan_y_q), LEFT)  ||
                        move_legal(board_q, int'(scan_x_q), int'(scan_y_q), RIGHT) ||
                        move_legal(board_q, int'(scan_x_q), int'(scan_y_q), UP)    ||
                        move_legal(board_q, int'(scan_x_q), int'(scan_y_q), DOWN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            board_q     <= INIT_BOARD;
            count_q     <= PW'(NCELLS - 1);
            cmd_undo_q  <= 1'b0;
            cmd_x_q     <= '0;
            cmd_y_q     <= '0;
            cmd_dir_q   <= LEFT;
            scan_x_q    <= '0;
            scan_y_q    <= '0;
            any_q       <= 1'b0;
            ok_q        <= 1'b0;
            from_cmd_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            game_over_q <= 1'b0;
            won_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            count_q     <= count_d;
            cmd_undo_q  <= cmd_undo_d;
            cmd_x_q     <= cmd_x_d;
            cmd_y_q     <= cmd_y_d;
            cmd_dir_q   <= cmd_dir_d;
            scan_x_q    <= scan_x_d;
            scan_y_q    <= scan_y_d;
            any_q       <= any_d;
            ok_q        <= ok_d;
            from_cmd_q  <= from_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            game_over_q <= game_over_d;
            won_q       <= won_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        int ux;
        int uy;
        int udx;
        int udy;
        int cx;
        int cy;
        int cdx;
        int cdy;
        state_d      = state_q;
        board_d      = board_q;
        count_d      = count_q;
        cmd_undo_d   = cmd_undo_q;
        cmd_x_d      = cmd_x_q;
        cmd_y_d      = cmd_y_q;
        cmd_dir_d    = cmd_dir_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        any_d        = any_q;
        ok_d         = ok_q;
        from_cmd_d   = from_cmd_q;
        rsp_valid_d  = 1'b0;
        rsp_ok_d     = rsp_ok_q;
        game_over_d  = game_over_q;
        won_d        = won_q;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        push_entry_c = '{x: COORD_W'(cmd_x_q), y: COORD_W'(cmd_y_q), dir: cmd_dir_q};
        ux           = int'(top_entry_c.x);
        uy           = int'(top_entry_c.y);
        udx          = dir_dx(top_entry_c.dir);
        udy          = dir_dy(top_entry_c.dir);
        cx           = int'(cmd_x_q);
        cy           = int'(cmd_y_q);
        cdx          = dir_dx(cmd_dir_q);
        cdy          = dir_dy(cmd_dir_q);

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    cmd_undo_d = cmd_undo;
                    cmd_x_d    = cmd_x;
                    cmd_y_d    = cmd_y;
                    cmd_dir_d  = dir_e'(cmd_dir);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                ok_d = 1'b0;
                if (cmd_undo_q) begin
                    // Popped entries always came from legal moves, so their cells exist.
                    if (level != '0) begin
                        board_d[cell_idx(ux + 2 * udx, uy + 2 * udy)] = 1'b0;
                        board_d[cell_idx(ux + udx, uy + udy)]         = 1'b1;
                        board_d[cell_idx(ux, uy)]                     = 1'b1;
                        count_d = count_q + PW'(1);
                        pop_c   = 1'b1;
                        ok_d    = 1'b1;
                    end
                end else if (move_legal(board_q, cx, cy, cmd_dir_q)) begin
                    board_d[cell_idx(cx, cy)]                     = 1'b0;
                    board_d[cell_idx(cx + cdx, cy + cdy)]         = 1'b0;
                    board_d[cell_idx(cx + 2 * cdx, cy + 2 * cdy)] = 1'b1;
                    count_d = count_q - PW'(1);
                    push_c  = 1'b1;
                    ok_d    = 1'b1;
                end
                from_cmd_d = 1'b1;
                scan_x_d   = '0;
                scan_y_d   = '0;
                any_d      = 1'b0;
                state_d    = SCAN;
            end
            SCAN: begin
                any_d = any_q || scan_hit_c;
                if ((scan_x_q == CW'(BOARD_WIDTH - 1)) && (scan_y_q == CW'(BOARD_WIDTH - 1))) begin
                    state_d    = IDLE;
                    from_cmd_d = 1'b0;
                    // The post-reset scan leaves status untouched and raises no response.
                    if (from_cmd_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_ok_d    = ok_q;
                        game_over_d = !(any_q || scan_hit_c);
                        won_d       = !(any_q || scan_hit_c) && (count_q == PW'(1)) &&
                                      board_q[IW'(CENTRE)];
                    end
                end else if (scan_x_q == CW'(BOARD_WIDTH - 1)) begin
                    scan_x_d = '0;
                    scan_y_d = scan_y_q + CW'(1);
                end else begin
                    scan_x_d = scan_x_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign piece_count = count_q;
    assign undo_level  = level;
    assign game_over   = game_over_q;
    assign won         = won_q;

endmodule
